coupling_weight_loader: RTL and testbench
=========================================

// Module: coupling_weight_loader
// PURPOSE
//   Register-based writer for the coupling weights of an N x N coupled-RO cell array.
//   Replaces hard-wired weight buses.
//   - Accepts (row, col, weight) writes over a valid/ready handshake.
//   - Keeps the matrix symmetric: every write updates [r][c] and [c][r].
//   - Drives a flat weight bus into the oscillator array.
//   - Offers a clear sweep, and freezes the matrix while the array is annealing.
// PARAMETERS
//   N            4  oscillators per side; the array holds N*N weight slots
//   NUM_WEIGHTS  5  number of legal weight codes (0..NUM_WEIGHTS-1), as used by the cells
//   WW           $clog2(NUM_WEIGHTS)  width of one weight code (derived; do not override)
//   AW           $clog2(N)            width of a row or column index (derived)
// PORTS
//   clk          in   1        single clock
//   rst          in   1        asynchronous, active-high reset
//   run          in   1        array is annealing; while high, writes and clear start are blocked
//   wr_valid     in   1        write request
//   wr_ready     out  1        write is accepted on any edge where wr_valid && wr_ready
//   wr_row       in   AW       row index
//   wr_col       in   AW       column index
//   wr_weight    in   WW       weight code
//   clr_start    in   1        one-cycle pulse: reset every slot to DEFAULT_W
//   busy         out  1        clear sweep in progress
//   err          out  1        one-cycle pulse on an illegal write
//   wr_count     out  16       count of accepted legal writes; wraps at 2^16
//   weights_out  out  N*N*WW   slot [r][c] sits at bits [(r*N+c)*WW +: WW]
// BEHAVIOUR
//   - DEFAULT_W = (NUM_WEIGHTS-1)/2, the neutral (zero-coupling) code.
//   - Reset, asynchronous:
//     - every slot = DEFAULT_W; FSM = IDLE; busy=0, err=0, wr_count=0
//     - wr_ready=0 while rst is high
//     - a clear or write in flight is abandoned with no partial result kept
//   - FSM states: IDLE, CLEAR.
//     - IDLE -> CLEAR: on clr_start && !run. row_ptr = 0, busy = 1 from the next cycle.
//     - CLEAR: each cycle, row row_ptr and column row_ptr are set to DEFAULT_W and row_ptr increments.
//     - CLEAR -> IDLE: after the cycle with row_ptr == N-1. The sweep takes exactly N cycles, then busy=0.
//     - clr_start while busy or while run is ignored.
//     - run rising during CLEAR does not stop the sweep.
//   - wr_ready = (state==IDLE) && !run && !clr_start && !rst. This is combinational, and clear wins a same-cycle tie.
//   - Accepted write at edge k:
//     - slots [r][c] and [c][r] take wr_weight in the same edge
//     - weights_out shows the new value from cycle k+1 (latency 1)
//     - wr_count increments
//   - Illegal write, accepted but not applied: err pulses at k+1 and wr_count is unchanged. Illegal means any of:
//     - wr_weight >= NUM_WEIGHTS
//     - wr_row >= N or wr_col >= N (possible when N is not a power of 2)
//     - wr_row == wr_col (diagonal: no self-coupling)
//   - Back-to-back writes are accepted one per cycle. A later write to the same pair overwrites the earlier one.
//   - weights_out is driven directly from flops (no combinational path from the inputs), so the ring oscillators never see a glitch.
// STRUCTURE
//   - Shared include coupling_defs.vh: DEFAULT_W macro/function, WW/AW derivations, FSM state encodings (IDLE=0, CLEAR=1).
//     coupled_cell and the array top use the same file.
//   - Sub-module weight_slot: one WW-bit register.
//     - async reset to DEFAULT_W
//     - write-enable + data, plus a synchronous clear-to-default input
//     - instantiated N*N times in a generate loop
//   - The loader owns the FSM, the address decode, the legality checks and the counter.
// TESTING
//   1. Reset release, N=4, NUM_WEIGHTS=5 -> every slot reads 2, wr_ready=1, busy=0, err=0.
//   2. Write (row=1, col=3, w=4) -> next cycle slots [1][3] and [3][1] are 4, all others 2; wr_count=1.
//   3. Write w=5, then (2,2,w=1) -> err pulses one cycle each; weights_out and wr_count unchanged.
//   4. Load 3 writes, pulse clr_start with wr_valid also high:
//      -> write is not accepted; busy is high for 4 cycles; all slots are 2 afterwards.
//   5. Hold run=1 with wr_valid=1 -> wr_ready stays 0 and clr_start is ignored.
//      Drop run -> the write lands on the next edge.
//   6. Assert rst in the middle of a clear sweep -> all slots are 2 immediately; busy=0; wr_count=0.

Source files
------------

// File: rtl/coupling_weight_loader_pkg.sv
// coupling_weight_loader_pkg
//   Shared definitions for the coupling weight loader and its slot registers:
//   the loader FSM state encoding and the neutral-weight helper.
package coupling_weight_loader_pkg;

  // Loader FSM states; the encodings are fixed because other array blocks
  // decode them.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Neutral (zero-coupling) weight code for a cell with num_weights codes.
  function automatic int default_w(input int num_weights);
    return (num_weights - 1) / 2;
  endfunction

endpackage

// File: rtl/coupling_weight_loader_weight_slot.sv
// weight_slot
//   One coupling weight register. It resets asynchronously to the neutral
//   code and can be cleared to the neutral code synchronously.
//   Ports:
//     clk  in   clock
//     rst  in   asynchronous active-high reset
//     we   in   load d on the next edge
//     clr  in   load the neutral code on the next edge (wins over we)
//     d    in   WW-bit weight code
//     q    out  WW-bit stored weight code
module weight_slot
  import coupling_weight_loader_pkg::*;
#(
  parameter int NUM_WEIGHTS = 5,
  parameter int WW          = $clog2(NUM_WEIGHTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          clr,
  input  logic [WW-1:0] d,
  output logic [WW-1:0] q
);

  localparam logic [WW-1:0] DEF = WW'(default_w(NUM_WEIGHTS));

  // Clear has priority so a sweep always leaves the slot neutral.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= DEF;
    end else if (clr) begin
      q <= DEF;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/coupling_weight_loader.sv
// coupling_weight_loader
//   Writes the coupling weights of an N x N coupled-RO array over a
//   valid/ready interface while keeping the matrix symmetric, offers a clear
//   sweep back to the neutral code, and freezes the matrix while the array
//   anneals.
//   Ports:
//     clk          in   clock
//     rst          in   asynchronous active-high reset
//     run          in   array annealing; blocks writes and clear start
//     wr_valid     in   write request
//     wr_ready     out  write accepted on an edge with wr_valid && wr_ready
//     wr_row       in   AW-bit row index
//     wr_col       in   AW-bit column index
//     wr_weight    in   WW-bit weight code
//     clr_start    in   pulse: reset every slot to the neutral code
//     busy         out  clear sweep in progress
//     err          out  one-cycle pulse after an illegal accepted write
//     wr_count     out  count of accepted legal writes (wraps)
//     weights_out  out  slot [r][c] at bits [(r*N+c)*WW +: WW]
module coupling_weight_loader
  import coupling_weight_loader_pkg::*;
#(
  parameter  int N           = 4,
  parameter  int NUM_WEIGHTS = 5,
  localparam int WW          = $clog2(NUM_WEIGHTS),
  localparam int AW          = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_row,
  input  logic [AW-1:0]     wr_col,
  input  logic [WW-1:0]     wr_weight,
  input  logic              clr_start,
  output logic              busy,
  output logic              err,
  output logic [15:0]       wr_count,
  output logic [N*N*WW-1:0] weights_out
);

  localparam logic [WW:0]   NW_LIMIT = NUM_WEIGHTS[WW:0];
  localparam logic [AW:0]   N_LIMIT  = N[AW:0];
  localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);

  state_t        state;
  logic [AW-1:0] row_ptr;
  logic          wr_accept;
  logic          wr_legal;
  logic          wr_apply;

  // A clear request in the same cycle takes priority over a write.
  assign wr_ready  = (state == IDLE) && !run && !clr_start && !rst;
  assign wr_accept = wr_valid && wr_ready;

  // Out-of-range codes, out-of-range indices and self-coupling are refused.
  assign wr_legal = ({1'b0, wr_weight} < NW_LIMIT) &&
                    ({1'b0, wr_row} < N_LIMIT) &&
                    ({1'b0, wr_col} < N_LIMIT) &&
                    (wr_row != wr_col);
  assign wr_apply = wr_accept && wr_legal;

  // Clear sweep FSM plus the error pulse and the accepted-write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row_ptr  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
    end else begin
      err <= wr_accept && !wr_legal;
      if (wr_apply) begin
        wr_count <= wr_count + 16'd1;
      end
      case (state)
        IDLE: begin
          if (clr_start && !run) begin
            state   <= CLEAR;
            row_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          row_ptr <= row_ptr + 1'b1;
          if (row_ptr == LAST_ROW) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // One register per slot; a write hits both [r][c] and [c][r], and a sweep
  // step clears the whole row and column row_ptr.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam logic [AW-1:0] RI = AW'(r);
      localparam logic [AW-1:0] CI = AW'(c);
      logic          slot_we;
      logic          slot_clr;
      logic [WW-1:0] slot_q;

      assign slot_we  = wr_apply &&
                        ((wr_row == RI && wr_col == CI) ||
                         (wr_row == CI && wr_col == RI));
      assign slot_clr = (state == CLEAR) && (row_ptr == RI || row_ptr == CI);

      weight_slot #(
        .NUM_WEIGHTS (NUM_WEIGHTS),
        .WW          (WW)
      ) u_slot (
        .clk (clk),
        .rst (rst),
        .we  (slot_we),
        .clr (slot_clr),
        .d   (wr_weight),
        .q   (slot_q)
      );

      assign weights_out[(r*N+c)*WW +: WW] = slot_q;
    end
  end

endmodule

// File: tb/tb_coupling_weight_loader.sv
// tb_coupling_weight_loader
//   Directed bench for coupling_weight_loader with N=4, NUM_WEIGHTS=5.
//   A small matrix model supplies the expected weight bus.
module tb_coupling_weight_loader;

  localparam int N  = 4;
  localparam int WW = 3;
  localparam int AW = 2;

  logic              clk;
  logic              rst;
  logic              run;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_row;
  logic [AW-1:0]     wr_col;
  logic [WW-1:0]     wr_weight;
  logic              clr_start;
  logic              busy;
  logic              err;
  logic [15:0]       wr_count;
  logic [N*N*WW-1:0] weights_out;

  int errors = 0;
  int checks = 0;
  int model [N][N];
  int busy_cycles;

  coupling_weight_loader #(
    .N           (4),
    .NUM_WEIGHTS (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_weight   (wr_weight),
    .clr_start   (clr_start),
    .busy        (busy),
    .err         (err),
    .wr_count    (wr_count),
    .weights_out (weights_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        model[r][c] = 2;
  endtask

  function automatic logic [N*N*WW-1:0] modelBus();
    logic [N*N*WW-1:0] bus;
    bus = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        bus[(r*N+c)*WW +: WW] = model[r][c][WW-1:0];
    return bus;
  endfunction

  // Present one write for a single edge; the model is updated only for
  // writes the bench expects to be legal.
  task automatic applyStimulus(input int r, input int c, input int w,
                               input bit legal);
    wr_valid  = 1'b1;
    wr_row    = AW'(r);
    wr_col    = AW'(c);
    wr_weight = WW'(w);
    step();
    wr_valid = 1'b0;
    if (legal) begin
      model[r][c] = w;
      model[c][r] = w;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; wr_valid = 1'b0; wr_row = '0; wr_col = '0;
    wr_weight = '0; clr_start = 1'b0;
    modelReset();
    #1;
    checkOutput("ready_in_reset", wr_ready, 0);
    step();
    step();
    rst = 1'b0;
    #1;

    // 1: reset state
    checkOutput("reset_weights", weights_out, modelBus());
    checkOutput("reset_ready", wr_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_count", wr_count, 0);

    // 2: symmetric write
    applyStimulus(1, 3, 4, 1'b1);
    checkOutput("w13_bus", weights_out, modelBus());
    checkOutput("w13_slot31", weights_out[(3*N+1)*WW +: WW], 4);
    checkOutput("w13_count", wr_count, 1);
    checkOutput("w13_err", err, 0);

    // 3: illegal weight, then diagonal
    applyStimulus(0, 1, 5, 1'b0);
    checkOutput("badw_err", err, 1);
    checkOutput("badw_bus", weights_out, modelBus());
    checkOutput("badw_count", wr_count, 1);
    applyStimulus(2, 2, 1, 1'b0);
    checkOutput("diag_err", err, 1);
    checkOutput("diag_bus", weights_out, modelBus());
    checkOutput("diag_count", wr_count, 1);
    step();
    checkOutput("err_drops", err, 0);

    // 4: three back-to-back writes (last overwrites [1][3]), then clear
    // with a competing write
    wr_valid = 1'b1;
    wr_row = 2'd0; wr_col = 2'd1; wr_weight = 3'd3; step();
    model[0][1] = 3; model[1][0] = 3;
    wr_row = 2'd2; wr_col = 2'd0; wr_weight = 3'd0; step();
    model[2][0] = 0; model[0][2] = 0;
    wr_row = 2'd3; wr_col = 2'd1; wr_weight = 3'd1; step();
    model[3][1] = 1; model[1][3] = 1;
    wr_valid = 1'b0;
    checkOutput("b2b_bus", weights_out, modelBus());
    checkOutput("b2b_count", wr_count, 4);

    wr_valid = 1'b1; wr_row = 2'd2; wr_col = 2'd3; wr_weight = 3'd4;
    clr_start = 1'b1;
    #1;
    checkOutput("clr_tie_ready", wr_ready, 0);
    step();
    clr_start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      busy_cycles++;
      checkOutput("busy_ready", wr_ready, 0);
      // A clear request while busy must not restart the sweep.
      clr_start = (i == 1);
      step();
      clr_start = 1'b0;
    end
    wr_valid = 1'b0;
    modelReset();
    checkOutput("clr_busy_cycles", busy_cycles, 4);
    checkOutput("clr_bus", weights_out, modelBus());
    checkOutput("clr_count", wr_count, 4);
    step();
    checkOutput("clr_no_restart", busy, 0);

    // 5: run freezes writes and clear start
    run = 1'b1;
    wr_valid = 1'b1; wr_row = 2'd0; wr_col = 2'd3; wr_weight = 3'd4;
    clr_start = 1'b1;
    #1;
    checkOutput("run_ready", wr_ready, 0);
    step();
    clr_start = 1'b0;
    checkOutput("run_busy", busy, 0);
    step();
    checkOutput("run_bus", weights_out, modelBus());
    checkOutput("run_count", wr_count, 4);
    run = 1'b0;
    #1;
    checkOutput("unrun_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    model[0][3] = 4; model[3][0] = 4;
    checkOutput("unrun_bus", weights_out, modelBus());
    checkOutput("unrun_count", wr_count, 5);

    // 6: reset in the middle of a sweep
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    step();
    checkOutput("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_mid_bus", weights_out, modelBus());
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_count", wr_count, 0);
    checkOutput("rst_mid_ready", wr_ready, 0);
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_ready", wr_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
